id_ex_pipeline_register: RTL and testbench
==========================================

// Module: id_ex_pipeline_register
// PURPOSE
//   ID/EX boundary register of the five-stage pipeline. Captures decoded operands,
//   ALU control (3-bit code consumed directly by the ALU), shamt and control flags
//   at the end of decode and presents them to the EX stage one cycle later.
//   Supports stall (hold), flush (bubble insertion) and write-back bypass so that
//   operands held or captured in this register never go stale.
// PARAMETERS
//   DATA_W      32  operand / PC / immediate width
//   REG_ADDR_W  5   register-file index width
// PORTS
//   clk             in   1           rising-edge clock
//   rst_n           in   1           asynchronous active-low reset
//   stall           in   1           hold current contents (load-use hazard)
//   flush           in   1           replace contents with bubble (branch/jump taken)
//   id_valid        in   1           decode holds a real instruction
//   id_pc           in   DATA_W      PC+4 of decoded instruction
//   id_rs_data      in   DATA_W      register-file read data, port A
//   id_rt_data      in   DATA_W      register-file read data, port B
//   id_imm          in   DATA_W      sign/zero-extended immediate
//   id_shamt        in   5           shift amount field
//   id_rs, id_rt, id_rd in REG_ADDR_W source/destination indices
//   id_alu_control  in   3           ALU op code (000 AND .. 111 SLL)
//   id_alu_src      in   1           1: operand2 = imm, 0: operand2 = rt data
//   id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in 1 each  control flags
//   wb_reg_write    in   1           write-back stage writes register file this cycle
//   wb_rd           in   REG_ADDR_W  write-back destination
//   wb_data         in   DATA_W      write-back value
//   ex_valid        out  1           EX holds a real instruction
//   ex_pc, ex_rs_data, ex_rt_data, ex_imm  out DATA_W  registered copies
//   ex_shamt        out  5;  ex_rs, ex_rt, ex_rd  out REG_ADDR_W
//   ex_alu_control  out  3;  ex_alu_src, ex_reg_write, ex_mem_read,
//   ex_mem_write, ex_mem_to_reg  out 1 each
// BEHAVIOUR
//   - All outputs registered; latency exactly 1 cycle ID -> EX. No combinational
//     path from any input to any output.
//   - Reset (rst_n=0, async): every output 0 (bubble); ex_alu_control=3'b000.
//     Deasserting rst_n mid-stream: first capture on next rising edge.
//   - Per-edge priority: flush > stall > load.
//     flush=1 : bubble -> ex_valid=0, ex_reg_write=ex_mem_read=ex_mem_write=
//               ex_mem_to_reg=0, all data/index fields 0. Applies even if stall=1.
//     stall=1 : all fields hold, EXCEPT bypass refresh below.
//     else    : load all id_* fields; if id_valid=0 load a bubble instead.
//   - Bubble always has zero side-effect flags; EX/MEM never writes state for it.
//   - WB bypass on load: if wb_reg_write && wb_rd!=0 && wb_rd==id_rs, capture
//     wb_data into ex_rs_data instead of id_rs_data; same independently for rt.
//     rs==rt both match -> both take wb_data.
//   - WB bypass on stall: if ex_valid && wb_reg_write && wb_rd!=0 && wb_rd==ex_rs
//     (resp. ex_rt), held ex_rs_data (resp. ex_rt_data) updated to wb_data.
//   - Register 0 never bypassed: wb_rd==0 has no effect.
//   - ex_alu_src/ex_imm passed through untouched; operand2 muxing is EX's job.
//   - Widths fixed; no truncation or extension performed here.
// TESTING
//   1 Reset: rst_n=0 async mid-cycle -> all outputs 0 immediately, ex_valid=0.
//   2 Load: id_valid=1, rs_data=0x11, rt_data=0x22, alu_control=3'b010 -> next edge
//     ex_* equal inputs, ex_valid=1; following edge with new data updates again.
//   3 Stall: stall=1 for 3 cycles with changing id_* -> ex_* hold; release ->
//     captures current id_* on next edge.
//   4 Flush vs stall: flush=1, stall=1, id_reg_write=1 -> ex_valid=0,
//     ex_reg_write=0, ex_rs_data=0.
//   5 Bypass: id_rs=5, wb_rd=5, wb_reg_write=1, wb_data=0xDEADBEEF,
//     id_rs_data=0x0 -> ex_rs_data=0xDEADBEEF; repeat with wb_rd=0 -> ex_rs_data=0x0.
//   6 Stall bypass: held ex_rt=7, stall=1, wb writes r7=0x1234 -> ex_rt_data=0x1234
//     after edge, other fields unchanged.

Source files
------------

// File: rtl/id_ex_pipeline_register.sv
// ---------------------------------------------------------------------------
// id_ex_pipeline_register
//
// Boundary register between the decode (ID) and execute (EX) stages of the
// five-stage pipeline. Decoded operands, immediate, shift amount, register
// indices, the 3-bit ALU code and the memory/write-back control flags are
// captured at the end of decode and presented to EX one cycle later.
//
// Ports
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low reset (contents become a bubble)
//   stall_i             hold the current contents (load-use hazard)
//   flush_i             replace the contents with a bubble; wins over stall_i
//   id_valid_i          decode holds a real instruction
//   id_pc_i             PC+4 of the decoded instruction
//   id_rs_data_i        register-file read data, port A
//   id_rt_data_i        register-file read data, port B
//   id_imm_i            extended immediate
//   id_shamt_i          shift amount field
//   id_rs_i/rt_i/rd_i   source / destination register indices
//   id_alu_control_i    ALU op code consumed directly by the ALU
//   id_alu_src_i        operand2 select, forwarded untouched to EX
//   id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i
//                       control flags
//   wb_reg_write_i      write-back stage writes the register file this cycle
//   wb_rd_i             write-back destination index
//   wb_data_i           write-back value
//   ex_*_o              registered copies of the id_* fields, plus ex_valid_o
// ---------------------------------------------------------------------------
module id_ex_pipeline_register #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  id_valid_i,
  input  logic [DATA_W-1:0]     id_pc_i,
  input  logic [DATA_W-1:0]     id_rs_data_i,
  input  logic [DATA_W-1:0]     id_rt_data_i,
  input  logic [DATA_W-1:0]     id_imm_i,
  input  logic [4:0]            id_shamt_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic [2:0]            id_alu_control_i,
  input  logic                  id_alu_src_i,
  input  logic                  id_reg_write_i,
  input  logic                  id_mem_read_i,
  input  logic                  id_mem_write_i,
  input  logic                  id_mem_to_reg_i,
  input  logic                  wb_reg_write_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic [DATA_W-1:0]     wb_data_i,
  output logic                  ex_valid_o,
  output logic [DATA_W-1:0]     ex_pc_o,
  output logic [DATA_W-1:0]     ex_rs_data_o,
  output logic [DATA_W-1:0]     ex_rt_data_o,
  output logic [DATA_W-1:0]     ex_imm_o,
  output logic [4:0]            ex_shamt_o,
  output logic [REG_ADDR_W-1:0] ex_rs_o,
  output logic [REG_ADDR_W-1:0] ex_rt_o,
  output logic [REG_ADDR_W-1:0] ex_rd_o,
  output logic [2:0]            ex_alu_control_o,
  output logic                  ex_alu_src_o,
  output logic                  ex_reg_write_o,
  output logic                  ex_mem_read_o,
  output logic                  ex_mem_write_o,
  output logic                  ex_mem_to_reg_o
);

  typedef struct packed {
    logic                  valid;
    logic [DATA_W-1:0]     pc;
    logic [DATA_W-1:0]     rs_data;
    logic [DATA_W-1:0]     rt_data;
    logic [DATA_W-1:0]     imm;
    logic [4:0]            shamt;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [2:0]            alu_control;
    logic                  alu_src;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
  } entry_t;

  entry_t entry_q, entry_d;
  entry_t load_entry, hold_entry;

  // Register 0 is hard-wired, so a write-back to it must never be forwarded.
  logic wb_live;
  assign wb_live = wb_reg_write_i && (wb_rd_i != '0);

  // Entry captured from decode. A non-valid decode slot becomes an all-zero
  // bubble so EX/MEM can never act on stale control flags.
  always_comb begin
    load_entry = '0;
    if (id_valid_i) begin
      load_entry.valid       = 1'b1;
      load_entry.pc          = id_pc_i;
      load_entry.rs_data     = (wb_live && (wb_rd_i == id_rs_i)) ? wb_data_i : id_rs_data_i;
      load_entry.rt_data     = (wb_live && (wb_rd_i == id_rt_i)) ? wb_data_i : id_rt_data_i;
      load_entry.imm         = id_imm_i;
      load_entry.shamt       = id_shamt_i;
      load_entry.rs          = id_rs_i;
      load_entry.rt          = id_rt_i;
      load_entry.rd          = id_rd_i;
      load_entry.alu_control = id_alu_control_i;
      load_entry.alu_src     = id_alu_src_i;
      load_entry.reg_write   = id_reg_write_i;
      load_entry.mem_read    = id_mem_read_i;
      load_entry.mem_write   = id_mem_write_i;
      load_entry.mem_to_reg  = id_mem_to_reg_i;
    end
  end

  // While stalled the operands keep tracking write-back, otherwise a value
  // retired during the stall would be lost to the held instruction.
  always_comb begin
    hold_entry = entry_q;
    if (entry_q.valid && wb_live) begin
      if (wb_rd_i == entry_q.rs) hold_entry.rs_data = wb_data_i;
      if (wb_rd_i == entry_q.rt) hold_entry.rt_data = wb_data_i;
    end
  end

  // Flush beats stall so a taken branch can squash an instruction that is
  // simultaneously waiting on a load-use hazard.
  always_comb begin
    entry_d = load_entry;
    if (flush_i) begin
      entry_d = '0;
    end else if (stall_i) begin
      entry_d = hold_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign ex_valid_o       = entry_q.valid;
  assign ex_pc_o          = entry_q.pc;
  assign ex_rs_data_o     = entry_q.rs_data;
  assign ex_rt_data_o     = entry_q.rt_data;
  assign ex_imm_o         = entry_q.imm;
  assign ex_shamt_o       = entry_q.shamt;
  assign ex_rs_o          = entry_q.rs;
  assign ex_rt_o          = entry_q.rt;
  assign ex_rd_o          = entry_q.rd;
  assign ex_alu_control_o = entry_q.alu_control;
  assign ex_alu_src_o     = entry_q.alu_src;
  assign ex_reg_write_o   = entry_q.reg_write;
  assign ex_mem_read_o    = entry_q.mem_read;
  assign ex_mem_write_o   = entry_q.mem_write;
  assign ex_mem_to_reg_o  = entry_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// ---------------------------------------------------------------------------
// tb_id_ex_pipeline_register
//
// Directed and randomized stimulus for the ID/EX register. Each driven cycle
// pushes the predicted EX contents onto a scoreboard queue; the entry is
// popped and compared one edge later.
// ---------------------------------------------------------------------------
module tb_id_ex_pipeline_register;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [2:0]  aluControl;
    logic        aluSrc;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        memToReg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic        stall, flush, idValid;
  logic [31:0] idPc, idRsData, idRtData, idImm;
  logic [4:0]  idShamt, idRs, idRt, idRd;
  logic [2:0]  idAluControl;
  logic        idAluSrc, idRegWrite, idMemRead, idMemWrite, idMemToReg;
  logic        wbRegWrite;
  logic [4:0]  wbRd;
  logic [31:0] wbData;

  logic        exValid;
  logic [31:0] exPc, exRsData, exRtData, exImm;
  logic [4:0]  exShamt, exRs, exRt, exRd;
  logic [2:0]  exAluControl;
  logic        exAluSrc, exRegWrite, exMemRead, exMemWrite, exMemToReg;

  int   checks   = 0;
  int   failures = 0;
  exp_t model    = '0;
  exp_t scoreQ[$];

  always #5 clk = ~clk;

  id_ex_pipeline_register #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk              (clk),
    .rst_n            (rstN),
    .stall_i          (stall),
    .flush_i          (flush),
    .id_valid_i       (idValid),
    .id_pc_i          (idPc),
    .id_rs_data_i     (idRsData),
    .id_rt_data_i     (idRtData),
    .id_imm_i         (idImm),
    .id_shamt_i       (idShamt),
    .id_rs_i          (idRs),
    .id_rt_i          (idRt),
    .id_rd_i          (idRd),
    .id_alu_control_i (idAluControl),
    .id_alu_src_i     (idAluSrc),
    .id_reg_write_i   (idRegWrite),
    .id_mem_read_i    (idMemRead),
    .id_mem_write_i   (idMemWrite),
    .id_mem_to_reg_i  (idMemToReg),
    .wb_reg_write_i   (wbRegWrite),
    .wb_rd_i          (wbRd),
    .wb_data_i        (wbData),
    .ex_valid_o       (exValid),
    .ex_pc_o          (exPc),
    .ex_rs_data_o     (exRsData),
    .ex_rt_data_o     (exRtData),
    .ex_imm_o         (exImm),
    .ex_shamt_o       (exShamt),
    .ex_rs_o          (exRs),
    .ex_rt_o          (exRt),
    .ex_rd_o          (exRd),
    .ex_alu_control_o (exAluControl),
    .ex_alu_src_o     (exAluSrc),
    .ex_reg_write_o   (exRegWrite),
    .ex_mem_read_o    (exMemRead),
    .ex_mem_write_o   (exMemWrite),
    .ex_mem_to_reg_o  (exMemToReg)
  );

  // Gather the DUT outputs into the same layout the predictor uses.
  function automatic exp_t observed();
    exp_t o;
    o = {exValid, exPc, exRsData, exRtData, exImm, exShamt, exRs, exRt, exRd,
         exAluControl, exAluSrc, exRegWrite, exMemRead, exMemWrite, exMemToReg};
    return o;
  endfunction

  // Behavioural predictor: what EX should hold after the coming edge.
  function automatic exp_t predict(exp_t cur);
    exp_t n;
    n = '0;
    if (flush) begin
      n = '0;
    end else if (stall) begin
      n = cur;
      if (cur.valid && wbRegWrite && wbRd != 5'd0 && wbRd == cur.rs) n.rsData = wbData;
      if (cur.valid && wbRegWrite && wbRd != 5'd0 && wbRd == cur.rt) n.rtData = wbData;
    end else if (idValid) begin
      n.valid      = 1'b1;
      n.pc         = idPc;
      n.rsData     = idRsData;
      n.rtData     = idRtData;
      if (wbRegWrite && wbRd != 5'd0) begin
        if (wbRd == idRs) n.rsData = wbData;
        if (wbRd == idRt) n.rtData = wbData;
      end
      n.imm        = idImm;
      n.shamt      = idShamt;
      n.rs         = idRs;
      n.rt         = idRt;
      n.rd         = idRd;
      n.aluControl = idAluControl;
      n.aluSrc     = idAluSrc;
      n.regWrite   = idRegWrite;
      n.memRead    = idMemRead;
      n.memWrite   = idMemWrite;
      n.memToReg   = idMemToReg;
    end
    return n;
  endfunction

  task automatic setWb(input logic we, input logic [4:0] rd, input logic [31:0] data);
    wbRegWrite = we;
    wbRd       = rd;
    wbData     = data;
  endtask

  // Drive one cycle of decode-side inputs and record the predicted result.
  // ctl = {alu_src, reg_write, mem_read, mem_write, mem_to_reg}
  task automatic applyStimulus(input logic st, input logic fl, input logic v,
                               input logic [31:0] pc, input logic [31:0] rsd,
                               input logic [31:0] rtd, input logic [31:0] imm,
                               input logic [4:0] sh, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd,
                               input logic [2:0] alu, input logic [4:0] ctl);
    stall        = st;
    flush        = fl;
    idValid      = v;
    idPc         = pc;
    idRsData     = rsd;
    idRtData     = rtd;
    idImm        = imm;
    idShamt      = sh;
    idRs         = rs;
    idRt         = rt;
    idRd         = rd;
    idAluControl = alu;
    {idAluSrc, idRegWrite, idMemRead, idMemWrite, idMemToReg} = ctl;
    model = predict(model);
    scoreQ.push_back(model);
  endtask

  // Advance one edge, then compare against the oldest prediction.
  task automatic checkOutput(input string tag);
    exp_t e, o;
    @(posedge clk);
    #1;
    checks++;
    if (scoreQ.size() == 0) begin
      failures++;
      $error("[TB] FAIL %s observed=no-prediction expected=queued-entry", tag);
    end else begin
      e = scoreQ.pop_front();
      o = observed();
      assert (o === e) else begin
        failures++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, o, e);
      end
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rstN = 1'b0;
    setWb(1'b0, 5'd0, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 5'b0);
    scoreQ.delete();
    model = '0;
    #12;
    checks++;
    assert (observed() === exp_t'('0)) else begin
      failures++;
      $error("[TB] FAIL reset_state observed=%h expected=0", observed());
    end
    @(negedge clk);
    rstN = 1'b1;

    // Plain loads
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h104, 32'h11, 32'h22, 32'h8, 5'd3, 5'd1, 5'd2, 5'd3, 3'b010, 5'b01000);
    checkOutput("load_a");
    checkValue("load_a_rs_data", exRsData, 32'h11);
    checkValue("load_a_alu", {29'd0, exAluControl}, 32'h2);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h108, 32'h33, 32'h44, 32'hFFFF_FFF0, 5'd31, 5'd4, 5'd6, 5'd8, 3'b111, 5'b11101);
    checkOutput("load_b");
    checkValue("load_b_valid", {31'd0, exValid}, 32'd1);

    // Stall for three cycles while decode keeps changing
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h200 + i, 32'hA0 + i, 32'hB0 + i, 32'h1, 5'd1, 5'd9, 5'd10, 5'd11, 3'b001, 5'b01010);
      checkOutput("stall_hold");
    end
    checkValue("stall_pc_held", exPc, 32'h108);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h300, 32'hC0, 32'hD0, 32'h2, 5'd2, 5'd12, 5'd13, 5'd14, 3'b011, 5'b01001);
    checkOutput("stall_release");

    // Flush wins over stall and yields a side-effect-free bubble
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h400, 32'hEE, 32'hFF, 32'h3, 5'd4, 5'd1, 5'd2, 5'd3, 3'b100, 5'b01110);
    checkOutput("flush_over_stall");
    checkValue("flush_reg_write", {31'd0, exRegWrite}, 32'd0);
    checkValue("flush_rs_data", exRsData, 32'd0);

    // Write-back bypass on load, including register 0 and rs==rt
    setWb(1'b1, 5'd5, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h500, 32'h0, 32'h55, 32'h0, 5'd0, 5'd5, 5'd6, 5'd7, 3'b010, 5'b01000);
    checkOutput("bypass_rs");
    checkValue("bypass_rs_data", exRsData, 32'hDEAD_BEEF);
    setWb(1'b1, 5'd0, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h504, 32'h0, 32'h55, 32'h0, 5'd0, 5'd0, 5'd0, 5'd7, 3'b010, 5'b01000);
    checkOutput("bypass_r0");
    checkValue("bypass_r0_rs_data", exRsData, 32'h0);
    setWb(1'b1, 5'd9, 32'h0BAD_F00D);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h508, 32'h1, 32'h2, 32'h0, 5'd0, 5'd9, 5'd9, 5'd7, 3'b000, 5'b01000);
    checkOutput("bypass_rs_rt_same");
    checkValue("bypass_same_rt_data", exRtData, 32'h0BAD_F00D);

    // Bypass into a held entry
    setWb(1'b0, 5'd0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h600, 32'h61, 32'h62, 32'h63, 5'd5, 5'd3, 5'd7, 5'd8, 3'b110, 5'b01000);
    checkOutput("load_rt7");
    setWb(1'b1, 5'd7, 32'h1234);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h700, 32'h71, 32'h72, 32'h73, 5'd1, 5'd1, 5'd2, 5'd3, 3'b001, 5'b00000);
    checkOutput("stall_bypass_rt");
    checkValue("stall_bypass_rt_data", exRtData, 32'h1234);
    checkValue("stall_bypass_rs_kept", exRsData, 32'h61);
    setWb(1'b0, 5'd3, 32'h9999);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h700, 32'h71, 32'h72, 32'h73, 5'd1, 5'd1, 5'd2, 5'd3, 3'b001, 5'b00000);
    checkOutput("stall_no_wb");

    // Invalid decode slot loads a bubble
    setWb(1'b0, 5'd0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h800, 32'h81, 32'h82, 32'h83, 5'd7, 5'd1, 5'd2, 5'd3, 3'b101, 5'b11111);
    checkOutput("invalid_bubble");

    // Randomized traffic with a small register range to provoke bypass hits
    for (int i = 0; i < 60; i++) begin
      setWb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      applyStimulus(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 4) != 0), $urandom, $urandom, $urandom, $urandom,
                    5'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom), 3'($urandom), 5'($urandom));
      checkOutput("random");
    end

    // Asynchronous reset in the middle of a cycle clears outputs immediately
    setWb(1'b0, 5'd0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h900, 32'h91, 32'h92, 32'h93, 5'd2, 5'd1, 5'd2, 5'd3, 3'b011, 5'b01111);
    checkOutput("pre_reset_load");
    #2;
    rstN = 1'b0;
    #1;
    checks++;
    assert (observed() === exp_t'('0)) else begin
      failures++;
      $error("[TB] FAIL async_reset observed=%h expected=0", observed());
    end
    model = '0;
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hA00, 32'hA1, 32'hA2, 32'hA3, 5'd4, 5'd4, 5'd5, 5'd6, 3'b100, 5'b01000);
    checkOutput("post_reset_load");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
